// File: rtl/serial_adder.sv
// Purpose : bit-serial WIDTH-bit adder; one full-add cell reused LSB->MSB, one bit per clock.
// Latency : WIDTH cycles from the accepted start edge to registered sum/cout and a done pulse.
// Backpr. : start is taken only while busy=0; start during busy is dropped, never queued.
//
// Ports:
//   clk, rst_n     - rising-edge clock, asynchronous active-low reset
//   start          - request, sampled only while busy=0
//   a, b, cin      - operands and carry-in, latched on an accepted start
//   busy           - high while an operation is in progress
//   done           - one-cycle pulse when sum/cout are updated
//   sum, cout      - registered result a + b + cin (cout = bit WIDTH)
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_psum;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_done;

  logic w_ha1, w_c1, w_s, w_c2, w_carry_nxt;
  logic w_last;
  logic w_accept, w_step, w_finish;
  logic [WIDTH-1:0] w_psum_nxt;

  // Shared full-add cell: two half adders plus carry OR.
  assign w_ha1       = r_opa[0] ^ r_opb[0];
  assign w_c1        = r_opa[0] & r_opb[0];
  assign w_s         = w_ha1 ^ r_carry;
  assign w_c2        = w_ha1 & r_carry;
  assign w_carry_nxt = w_c1 | w_c2;

  // New bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB.
  assign w_psum_nxt  = {w_s, r_psum[WIDTH-1:1]};
  assign w_last      = (r_cnt == LAST_BIT);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (start)  w_state_nxt = S_RUN;
      S_RUN:  if (w_last) w_state_nxt = S_IDLE;
      default:            w_state_nxt = S_IDLE;
    endcase
  end

  // Control decode
  always_comb begin
    w_accept = 1'b0;
    w_step   = 1'b0;
    w_finish = 1'b0;
    case (r_state)
      S_IDLE: w_accept = start;
      S_RUN: begin
        w_step   = 1'b1;
        w_finish = w_last;
      end
      default: ;
    endcase
  end

  // Datapath: operand shifters, carry, counter, partial sum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opa   <= '0;
      r_opb   <= '0;
      r_psum  <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
    end else if (w_accept) begin
      r_opa   <= a;
      r_opb   <= b;
      r_psum  <= '0;
      r_cnt   <= '0;
      r_carry <= cin;
    end else if (w_step) begin
      r_opa   <= {1'b0, r_opa[WIDTH-1:1]};
      r_opb   <= {1'b0, r_opb[WIDTH-1:1]};
      r_psum  <= w_psum_nxt;
      r_carry <= w_carry_nxt;
      // Counter stops at LAST_BIT; the FSM leaves RUN on that edge.
      if (!w_last) r_cnt <= r_cnt + CW'(1);
    end
  end

  // Result registers: updated only on the completion edge, held otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_finish) begin
        r_sum  <= w_psum_nxt;
        r_cout <= w_carry_nxt;
      end
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Purpose : directed self-checking bench for serial_adder (WIDTH=8).
// Latency : expects done WIDTH+1 negedges after the start is driven (8 busy cycles, then done).
// Backpr. : exercises start held high, start during busy, and mid-operation reset.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int n_tests;
  int n_fail;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // One operation: drive start for one edge, scramble operands mid-run,
  // count busy cycles until done, then check the result and the pulse width.
  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tc, input logic [W-1:0] es, input logic ec);
    int  nb;
    bit  seen;
    @(negedge clk);
    a = ta; b = tb_v; cin = tc; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; a = ~ta; b = ~tb_v; cin = ~tc;
    nb = 0; seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (busy) nb++;
        @(negedge clk);
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_busy_cycles"}, nb, W);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    check({tag, "_sum"}, 32'(sum), 32'(es));
    check({tag, "_cout"}, 32'(cout), 32'(ec));
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;

    // Reset state
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum",  32'(sum),  32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors
    run_op("zero",  8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    run_op("ripple",8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run_op("a5_5a", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);
    run_op("7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);

    // start held high: back-to-back ops every W+1 cycles, operands disturbed mid-run
    begin
      logic [W-1:0] hold_sum;
      logic         hold_cout;
      hold_sum = 8'h80; hold_cout = 1'b0;
      @(negedge clk);
      a = 8'h03; b = 8'h04; cin = 1'b0; start = 1'b1;
      @(posedge clk);
      for (int t = 1; t <= 3 * (W + 1); t++) begin
        @(negedge clk);
        if (t % (W + 1) == 0) begin
          check("b2b_done", 32'(done), 32'd1);
          check("b2b_busy_lo", 32'(busy), 32'd0);
          check("b2b_sum", 32'(sum), 32'h07);
          check("b2b_cout", 32'(cout), 32'd0);
          hold_sum = 8'h07; hold_cout = 1'b0;
        end else begin
          check("b2b_no_done", 32'(done), 32'd0);
          check("b2b_busy_hi", 32'(busy), 32'd1);
          check("b2b_sum_hold", 32'(sum), 32'(hold_sum));
          check("b2b_cout_hold", 32'(cout), 32'(hold_cout));
        end
        if (t % (W + 1) == 3) begin a = 8'hFF; b = 8'hFF; cin = 1'b1; end
        if (t % (W + 1) == 6) begin a = 8'h03; b = 8'h04; cin = 1'b0; end
        if (t == 3 * (W + 1)) start = 1'b0;
      end
      @(negedge clk);
      check("b2b_idle", 32'(busy), 32'd0);
    end

    // Mid-operation reset aborts without a done pulse
    begin
      bit saw_done;
      @(negedge clk);
      a = 8'hFF; b = 8'hFF; cin = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_sum",  32'(sum),  32'd0);
      check("abort_cout", 32'(cout), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      saw_done = 1'b0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (done || busy) saw_done = 1'b1;
      end
      check("abort_no_done", 32'(saw_done), 32'd0);
    end

    run_op("post_rst", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
